uart_tx: RTL and testbench

UART transmitter that consumes the transmit bit-rate tick from the baud generator and serialises bytes onto the TXD line. It requests ticks with tx_bps_en and advances exactly one bit per tx_bpsclk pulse, so every bit, including the start bit, lasts one full tick period. Bytes enter through a valid/ready write port backed by a small FIFO, so firmware or DMA can queue several characters ahead.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and the default frame width.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO queueing bytes ahead of the transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk26m,
  input  logic             rst26m,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk26m) begin
    if (rst26m) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk26m) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises queued bytes onto txd, advancing one bit per
// tx_bpsclk tick requested from the baud generator via tx_bps_en.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk26m,
  input  logic                 rst26m,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 tx_bpsclk,
  output logic                 tx_bps_en,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       txd_q, txd_d;
  logic       bps_en_q, bps_en_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       stop2_q, stop2_d;
  logic       pop;
  logic       done_c;
  logic       fifo_full;
  logic       fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk26m  (clk26m),
    .rst26m  (rst26m),
    .push    (wr_valid),
    .wr_data (wr_data),
    .full    (fifo_full),
    .pop     (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  assign wr_ready  = !fifo_full;
  assign txd       = txd_q;
  assign tx_bps_en = bps_en_q;
  assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_done   = done_c;

  always_ff @(posedge clk26m) begin
    if (rst26m) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      bps_en_q   <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      bps_en_q   <= bps_en_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
    end
  end

  // The data byte is shifted out LSB first, so parity is captured at pop time
  // while the whole byte is still available.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    bps_en_d   = bps_en_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_head;
          par_en_d  = parity_en;
          par_bit_d = (^fifo_head) ^ (parity_odd == PARITY_ODD);
          stop2_d   = stop2;
          bps_en_d  = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_bpsclk) begin
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_bpsclk) begin
          txd_d     = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_bpsclk) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              txd_d   = par_bit_q;
              state_d = ST_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tx_bpsclk) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tx_bpsclk) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_c = 1'b1;
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_d   = fifo_head;
              par_en_d  = parity_en;
              par_bit_d = (^fifo_head) ^ (parity_odd == PARITY_ODD);
              stop2_d   = stop2;
              txd_d     = 1'b0;
              state_d   = ST_START;
            end else begin
              bps_en_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: a line monitor decodes frames from txd and
// checks them against expected frames queued when each byte is written.
module tb_uart_tx;

  logic       clk26m = 1'b0;
  logic       rst26m;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       tx_bpsclk;
  logic       tx_bps_en;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(
    .FIFO_DEPTH (4),
    .DATA_BITS  (8)
  ) dut (
    .clk26m     (clk26m),
    .rst26m     (rst26m),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .tx_bpsclk  (tx_bpsclk),
    .tx_bps_en  (tx_bps_en),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #19 clk26m = ~clk26m;

  // Baud generator model: period 16, cleared while disabled, first tick
  // half a period after enable.
  logic [3:0] bcnt = '0;
  logic       man_tick = 1'b0;
  always @(posedge clk26m) begin
    if (!tx_bps_en) bcnt <= '0;
    else            bcnt <= bcnt + 4'd1;
  end
  assign tx_bpsclk = (tx_bps_en && bcnt == 4'd7) || man_tick;

  int unsigned cyc = 0;
  always @(posedge clk26m) cyc <= cyc + 1;

  int unsigned done_cnt = 0;
  always @(negedge clk26m) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pb;
    int unsigned ns;
  } exp_t;

  exp_t        sb[$];
  int unsigned starts[$];
  int unsigned dones[$];
  int unsigned frames_done = 0;

  // Line monitor: samples each bit at mid-period and times the frame to tx_done.
  initial begin : monitor
    exp_t        e;
    int unsigned t0;
    int unsigned k;
    int unsigned nbits;
    logic [7:0]  got;
    logic        gstart;
    logic        gpar;
    logic        gstop;
    forever begin
      @(negedge clk26m);
      if (sb.size() > 0 && txd === 1'b0 && rst26m === 1'b0) begin
        e  = sb.pop_front();
        t0 = cyc;
        repeat (8) @(negedge clk26m);
        gstart = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk26m);
          got[i] = txd;
        end
        gpar = 1'b0;
        if (e.pe) begin
          repeat (16) @(negedge clk26m);
          gpar = txd;
        end
        gstop = 1'b1;
        for (int s = 0; s < int'(e.ns); s++) begin
          repeat (16) @(negedge clk26m);
          gstop = gstop & txd;
        end
        k = 0;
        while (tx_done !== 1'b1 && k < 24) begin
          @(negedge clk26m);
          k++;
        end
        nbits = 1 + 8 + (e.pe ? 1 : 0) + e.ns;
        chk("start_bit", {31'd0, gstart}, 32'd0);
        chk("data_bits", {24'd0, got}, {24'd0, e.data});
        if (e.pe) chk("parity_bit", {31'd0, gpar}, {31'd0, e.pb});
        chk("stop_bits", {31'd0, gstop}, 32'd1);
        chk("frame_len", cyc - t0, 16 * nbits - 1);
        starts.push_back(t0);
        dones.push_back(cyc);
        frames_done++;
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic pb, input bit track);
    int unsigned k = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!wr_ready && k < 2000) begin
      @(negedge clk26m);
      k++;
    end
    chk("push_accept", {31'd0, wr_ready}, 32'd1);
    if (track) sb.push_back('{data: d, pe: parity_en, pb: pb, ns: stop2 ? 2 : 1});
    @(negedge clk26m);
    wr_valid = 1'b0;
  endtask

  task automatic wait_frames(input int unsigned n, input bit chk_busy);
    int unsigned k = 0;
    bit dropped = 1'b0;
    while (frames_done < n && k < 3000) begin
      @(negedge clk26m);
      k++;
      if (chk_busy && frames_done < n && !tx_busy) dropped = 1'b1;
    end
    chk("frame_timeout", {31'd0, (k < 3000)}, 32'd1);
    if (chk_busy) chk("busy_held", {31'd0, dropped}, 32'd0);
    repeat (2) @(negedge clk26m);
  endtask

  initial begin : watchdog
    #(38 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int unsigned d0;
    int unsigned base;
    int unsigned k;
    logic [7:0] t4 [6];
    t4 = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3, 8'h7E};

    rst26m = 1'b1; wr_data = '0; wr_valid = 1'b0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk26m);
    chk("rst_txd",      {31'd0, txd},       32'd1);
    chk("rst_bps_en",   {31'd0, tx_bps_en}, 32'd0);
    chk("rst_busy",     {31'd0, tx_busy},   32'd0);
    chk("rst_done",     {31'd0, tx_done},   32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready},  32'd1);
    rst26m = 1'b0;
    @(negedge clk26m);

    // 1: 0x55, no parity, one stop bit
    d0 = done_cnt;
    push(8'h55, 1'b0, 1'b1);
    @(negedge clk26m);
    chk("t1_bps_en_rise", {31'd0, tx_bps_en}, 32'd1);
    wait_frames(1, 1'b0);
    chk("t1_done_count", done_cnt - d0, 32'd1);
    chk("t1_bps_en_fall", {31'd0, tx_bps_en}, 32'd0);
    chk("t1_txd_idle",    {31'd0, txd},       32'd1);

    // 2: 0xA3 with even then odd parity
    parity_en = 1'b1; parity_odd = 1'b0;
    push(8'hA3, 1'b0, 1'b1);
    wait_frames(2, 1'b0);
    parity_odd = 1'b1;
    push(8'hA3, 1'b1, 1'b1);
    wait_frames(3, 1'b0);

    // 3: two stop bits; stop2 dropped mid-frame must not affect this frame
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    push(8'h00, 1'b0, 1'b1);
    repeat (50) @(negedge clk26m);
    stop2 = 1'b0;
    wait_frames(4, 1'b0);

    // 4: six bytes; one goes straight to the shifter, four fill the FIFO
    base = frames_done;
    for (int i = 0; i < 5; i++) push(t4[i], 1'b0, 1'b1);
    chk("t4_full_ready", {31'd0, wr_ready}, 32'd0);
    chk("t4_busy", {31'd0, tx_busy}, 32'd1);
    push(t4[5], 1'b0, 1'b1);
    wait_frames(base + 6, 1'b1);
    for (int i = 0; i < 5; i++)
      chk("t4_contiguous", starts[base + i + 1], dones[base + i] + 1);

    // 5: reset during data bit 3
    d0 = done_cnt;
    push(8'h5A, 1'b0, 1'b0);
    k = 0;
    while (txd !== 1'b0 && k < 100) begin
      @(negedge clk26m);
      k++;
    end
    chk("t5_start_seen", {31'd0, (k < 100)}, 32'd1);
    repeat (70) @(negedge clk26m);
    rst26m = 1'b1;
    @(negedge clk26m);
    chk("t5_txd",      {31'd0, txd},       32'd1);
    chk("t5_bps_en",   {31'd0, tx_bps_en}, 32'd0);
    chk("t5_busy",     {31'd0, tx_busy},   32'd0);
    chk("t5_wr_ready", {31'd0, wr_ready},  32'd1);
    rst26m = 1'b0;
    repeat (100) @(negedge clk26m);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    chk("t5_txd_idle", {31'd0, txd}, 32'd1);

    // 6: stray tick while idle
    d0 = done_cnt;
    man_tick = 1'b1;
    @(negedge clk26m);
    man_tick = 1'b0;
    repeat (3) @(negedge clk26m);
    chk("t6_txd",    {31'd0, txd},       32'd1);
    chk("t6_busy",   {31'd0, tx_busy},   32'd0);
    chk("t6_bps_en", {31'd0, tx_bps_en}, 32'd0);
    chk("t6_done",   done_cnt - d0,      32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
